// File: rtl/video_pkg.sv
// Shared definitions for the PPU host register file.
// Contents: register index constants, ctrl/status bit positions, the palette
// region constant and a helper that tells whether an address lies in it.
package video_pkg;

   // Host register window indices
   localparam logic [2:0] REG_CTRL    = 3'd0;
   localparam logic [2:0] REG_MASK    = 3'd1;
   localparam logic [2:0] REG_STATUS  = 3'd2;
   localparam logic [2:0] REG_OAMADDR = 3'd3;
   localparam logic [2:0] REG_OAMDATA = 3'd4;
   localparam logic [2:0] REG_SCROLL  = 3'd5;
   localparam logic [2:0] REG_ADDR    = 3'd6;
   localparam logic [2:0] REG_DATA    = 3'd7;

   // ctrl bit positions
   localparam int CTRL_INC_BIT = 2;   // 0: +1 per data access, 1: +32
   localparam int CTRL_NMI_BIT = 7;   // NMI enable

   // status bit positions
   localparam int STAT_VBL_BIT = 7;
   localparam int STAT_S0_BIT  = 6;
   localparam int STAT_OVF_BIT = 5;

   // v[13:8] value that selects the palette
   localparam logic [5:0] PAL_REGION = 6'h3F;

   function automatic logic in_palette(input logic [14:0] v);
      return (v[13:8] == PAL_REGION);
   endfunction

endpackage

// File: rtl/video_regs_if.sv
// Host bus of the PPU register file.
// host_addr  : register index 0..7
// host_wren  : write level (the slave detects its rising edge)
// host_rden  : read level (the slave detects its rising edge)
// host_wdata : write data
// host_rdata : registered read data
// host_nmi   : active-low NMI
interface video_regs_if;
   logic [2:0] host_addr;
   logic       host_wren;
   logic       host_rden;
   logic [7:0] host_wdata;
   logic [7:0] host_rdata;
   logic       host_nmi;

   modport master (
      output host_addr, host_wren, host_rden, host_wdata,
      input  host_rdata, host_nmi
   );

   modport slave (
      input  host_addr, host_wren, host_rden, host_wdata,
      output host_rdata, host_nmi
   );
endinterface

// File: rtl/edge_trig.sv
// Rising-edge detector producing a one-clock registered pulse.
// I_clock : clock
// I_reset : asynchronous active-low reset
// I_level : level input
// O_pulse : high for the clock after I_level was first seen high
module edge_trig (
   input  logic I_clock,
   input  logic I_reset,
   input  logic I_level,
   output logic O_pulse
);

   logic level_q;
   logic pulse_q;

   // Previous level and registered rising-edge pulse
   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         level_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         level_q <= I_level;
         pulse_q <= I_level & ~level_q;
      end
   end

   assign O_pulse = pulse_q;

endmodule

// File: rtl/video_scroll.sv
// Scroll/address state: temporary address t, current address v, fine X and
// the shared write toggle w, plus the renderer copy/increment hooks.
// I_ctrl_wr   : ctrl write (loads t[11:10])
// I_scroll_wr : scroll register write
// I_addr_wr   : address register write
// I_data_acc  : data port access (advances v)
// I_inc32     : step v by 32 instead of 1 on data accesses
// I_status_rd : status read (clears w)
// I_wdata     : host write data
// I_copy_h/v, I_inc_x/y : renderer hooks
// O_v, O_fine_x : current address and fine X
module video_scroll (
   input  logic        I_clock,
   input  logic        I_reset,
   input  logic        I_ctrl_wr,
   input  logic        I_scroll_wr,
   input  logic        I_addr_wr,
   input  logic        I_data_acc,
   input  logic        I_inc32,
   input  logic        I_status_rd,
   input  logic [7:0]  I_wdata,
   input  logic        I_copy_h,
   input  logic        I_copy_v,
   input  logic        I_inc_x,
   input  logic        I_inc_y,
   output logic [14:0] O_v,
   output logic [2:0]  O_fine_x
);

   logic [14:0] t_q, t_d;
   logic [14:0] v_q, v_d;
   logic [14:0] v_x_s;
   logic [2:0]  fine_x_q, fine_x_d;
   logic        w_q, w_d;

   // Coarse X lives in v[4:0]; wrapping past 31 moves to the other
   // horizontal nametable (v[10]).
   function automatic logic [14:0] inc_coarse_x(input logic [14:0] v);
      logic [14:0] r;
      r = v;
      if (v[4:0] == 5'd31) begin
         r[4:0] = 5'd0;
         r[10]  = ~v[10];
      end else begin
         r[4:0] = v[4:0] + 5'd1;
      end
      return r;
   endfunction

   // Fine Y in v[14:12] carries into coarse Y v[9:5]. Row 29 is the last
   // visible tile row and flips the vertical nametable; rows 30/31 hold
   // attribute data, so 31 wraps without the flip.
   function automatic logic [14:0] inc_fine_y(input logic [14:0] v);
      logic [14:0] r;
      r = v;
      if (v[14:12] != 3'd7) begin
         r[14:12] = v[14:12] + 3'd1;
      end else begin
         r[14:12] = 3'd0;
         case (v[9:5])
            5'd29: begin
               r[9:5] = 5'd0;
               r[11]  = ~v[11];
            end
            5'd31:   r[9:5] = 5'd0;
            default: r[9:5] = v[9:5] + 5'd1;
         endcase
      end
      return r;
   endfunction

   // Host updates of t, fine X and w
   always_comb begin
      t_d      = t_q;
      fine_x_d = fine_x_q;
      w_d      = w_q;
      if (I_ctrl_wr) begin
         t_d[11:10] = I_wdata[1:0];
      end else if (I_scroll_wr) begin
         if (!w_q) begin
            t_d[4:0] = I_wdata[7:3];
            fine_x_d = I_wdata[2:0];
         end else begin
            t_d[9:5]   = I_wdata[7:3];
            t_d[14:12] = I_wdata[2:0];
         end
         w_d = ~w_q;
      end else if (I_addr_wr) begin
         if (!w_q) begin
            t_d[13:8] = I_wdata[5:0];
            t_d[14]   = 1'b0;
         end else begin
            t_d[7:0] = I_wdata;
         end
         w_d = ~w_q;
      end else if (I_status_rd) begin
         w_d = 1'b0;
      end else begin
         w_d = w_q;
      end
   end

   // Next v: host update, then renderer copies, then renderer increments
   always_comb begin
      v_x_s = I_inc_x ? inc_coarse_x(v_q) : v_q;
      v_d   = v_q;
      if (I_addr_wr && w_q) begin
         v_d = t_d;
      end else if (I_data_acc) begin
         v_d = v_q + (I_inc32 ? 15'd32 : 15'd1);
      end else if (I_copy_h || I_copy_v) begin
         if (I_copy_h) begin
            v_d[10]  = t_q[10];
            v_d[4:0] = t_q[4:0];
         end else begin
            v_d[10]  = v_q[10];
         end
         if (I_copy_v) begin
            v_d[14:11] = t_q[14:11];
            v_d[9:5]   = t_q[9:5];
         end else begin
            v_d[9:5]   = v_q[9:5];
         end
      end else begin
         v_d = I_inc_y ? inc_fine_y(v_x_s) : v_x_s;
      end
   end

   // Scroll state registers
   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         t_q      <= 15'd0;
         v_q      <= 15'd0;
         fine_x_q <= 3'd0;
         w_q      <= 1'b0;
      end else begin
         t_q      <= t_d;
         v_q      <= v_d;
         fine_x_q <= fine_x_d;
         w_q      <= w_d;
      end
   end

   assign O_v      = v_q;
   assign O_fine_x = fine_x_q;

endmodule

// File: rtl/video_regs.sv
// Host-visible PPU register file and VRAM/OAM access engine.
// I_clock, I_reset         : clock, asynchronous active-low reset
// host (video_regs_if)     : register window, read data, NMI
// I_set_vblank/I_clr_vblank: vblank pulses from timing
// I_sprite0_hit/ovf        : status levels from the renderer
// I_v_copy_h/v, I_v_inc_x/y: renderer scroll hooks
// O_vid_* / I_vid_data     : VRAM port;  I_pal_data : palette read data
// O_oam_* / I_oam_data     : OAM port
// O_ctrl, O_mask, O_vram_v, O_fine_x : state exported to the video core
module video_regs
   import video_pkg::*;
#(
   parameter int P_vram_latency   = 1,
   parameter int P_palette_bypass = 1,
   parameter int P_oam_addr_width = 8
) (
   input  logic                        I_clock,
   input  logic                        I_reset,
   video_regs_if.slave                 host,
   input  logic                        I_set_vblank,
   input  logic                        I_clr_vblank,
   input  logic                        I_sprite0_hit,
   input  logic                        I_sprite_ovf,
   input  logic                        I_v_copy_h,
   input  logic                        I_v_copy_v,
   input  logic                        I_v_inc_x,
   input  logic                        I_v_inc_y,
   output logic [13:0]                 O_vid_addr,
   output logic                        O_vid_wren,
   input  logic [7:0]                  I_vid_data,
   output logic [7:0]                  O_vid_data,
   input  logic [7:0]                  I_pal_data,
   output logic [P_oam_addr_width-1:0] O_oam_addr,
   output logic                        O_oam_wren,
   output logic [7:0]                  O_oam_data,
   input  logic [7:0]                  I_oam_data,
   output logic [7:0]                  O_ctrl,
   output logic [7:0]                  O_mask,
   output logic [14:0]                 O_vram_v,
   output logic [2:0]                  O_fine_x
);

   logic                        wr_stb_s, rd_stb_s;
   logic                        wr_s, rd_s;
   logic                        status_rd_s, data_acc_s, data_rd_s;
   logic [2:0]                  addr_q;
   logic [7:0]                  wdata_q;
   logic [7:0]                  ctrl_q, ctrl_d;
   logic [7:0]                  mask_q, mask_d;
   logic [7:0]                  openbus_q, openbus_d;
   logic [7:0]                  rdata_q, rdata_d;
   logic [7:0]                  rbuf_q, rbuf_d;
   logic [7:0]                  status_s;
   logic [P_oam_addr_width-1:0] oam_addr_q, oam_addr_d;
   logic                        vblank_q, vblank_d;
   logic                        nmi_q, nmi_d;
   logic [P_vram_latency-1:0]   pend_q, pend_d;
   logic [14:0]                 v_s;

   edge_trig u_wr_trig (.I_clock(I_clock), .I_reset(I_reset), .I_level(host.host_wren), .O_pulse(wr_stb_s));
   edge_trig u_rd_trig (.I_clock(I_clock), .I_reset(I_reset), .I_level(host.host_rden), .O_pulse(rd_stb_s));

   // A coincident write strobe suppresses the read
   assign wr_s        = wr_stb_s;
   assign rd_s        = rd_stb_s & ~wr_stb_s;
   assign status_rd_s = rd_s && (addr_q == REG_STATUS);
   assign data_rd_s   = rd_s && (addr_q == REG_DATA);
   assign data_acc_s  = (wr_s || rd_s) && (addr_q == REG_DATA);

   video_scroll u_scroll (
      .I_clock     (I_clock),
      .I_reset     (I_reset),
      .I_ctrl_wr   (wr_s && (addr_q == REG_CTRL)),
      .I_scroll_wr (wr_s && (addr_q == REG_SCROLL)),
      .I_addr_wr   (wr_s && (addr_q == REG_ADDR)),
      .I_data_acc  (data_acc_s),
      .I_inc32     (ctrl_q[CTRL_INC_BIT]),
      .I_status_rd (status_rd_s),
      .I_wdata     (wdata_q),
      .I_copy_h    (I_v_copy_h),
      .I_copy_v    (I_v_copy_v),
      .I_inc_x     (I_v_inc_x),
      .I_inc_y     (I_v_inc_y),
      .O_v         (v_s),
      .O_fine_x    (O_fine_x)
   );

   // Status byte: flags on top, stale bus bits underneath
   always_comb begin
      status_s               = {3'b000, openbus_q[4:0]};
      status_s[STAT_VBL_BIT] = vblank_q;
      status_s[STAT_S0_BIT]  = I_sprite0_hit;
      status_s[STAT_OVF_BIT] = I_sprite_ovf;
   end

   // Register-file next state
   always_comb begin
      ctrl_d     = ctrl_q;
      mask_d     = mask_q;
      oam_addr_d = oam_addr_q;
      openbus_d  = wr_s ? wdata_q : openbus_q;
      rdata_d    = rdata_q;
      if (wr_s) begin
         case (addr_q)
            REG_CTRL:    ctrl_d     = wdata_q;
            REG_MASK:    mask_d     = wdata_q;
            REG_OAMADDR: oam_addr_d = P_oam_addr_width'(wdata_q);
            REG_OAMDATA: oam_addr_d = oam_addr_q + P_oam_addr_width'(1);
            default:     ctrl_d     = ctrl_q;
         endcase
      end else if (rd_s) begin
         case (addr_q)
            REG_STATUS:  rdata_d = status_s;
            REG_OAMDATA: rdata_d = I_oam_data;
            REG_DATA:    rdata_d = ((P_palette_bypass != 0) && in_palette(v_s)) ? I_pal_data : rbuf_q;
            default:     rdata_d = openbus_q;
         endcase
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Vblank flag: clear pulse beats a status read, which beats (suppresses) set
   always_comb begin
      if (I_clr_vblank) begin
         vblank_d = 1'b0;
      end else if (status_rd_s) begin
         vblank_d = 1'b0;
      end else if (I_set_vblank) begin
         vblank_d = 1'b1;
      end else begin
         vblank_d = vblank_q;
      end
      nmi_d = ~(vblank_q & ctrl_q[CTRL_NMI_BIT]);
   end

   // Read-fetch tracking: bit i set means a fetch issued i+1 clocks ago;
   // the top bit marks the cycle in which I_vid_data is valid.
   always_comb begin
      pend_d    = '0;
      pend_d[0] = data_rd_s;
      for (int i = 1; i < P_vram_latency; i++) begin
         pend_d[i] = pend_q[i-1];
      end
      rbuf_d = pend_q[P_vram_latency-1] ? I_vid_data : rbuf_q;
   end

   // Host-side capture of address/data alongside the strobe
   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         addr_q  <= 3'd0;
         wdata_q <= 8'd0;
      end else begin
         addr_q  <= host.host_addr;
         wdata_q <= host.host_wdata;
      end
   end

   // Register file state
   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         ctrl_q     <= 8'd0;
         mask_q     <= 8'd0;
         oam_addr_q <= '0;
         openbus_q  <= 8'd0;
         rdata_q    <= 8'd0;
         rbuf_q     <= 8'd0;
         pend_q     <= '0;
         vblank_q   <= 1'b0;
         nmi_q      <= 1'b1;
      end else begin
         ctrl_q     <= ctrl_d;
         mask_q     <= mask_d;
         oam_addr_q <= oam_addr_d;
         openbus_q  <= openbus_d;
         rdata_q    <= rdata_d;
         rbuf_q     <= rbuf_d;
         pend_q     <= pend_d;
         vblank_q   <= vblank_d;
         nmi_q      <= nmi_d;
      end
   end

   assign host.host_rdata = rdata_q;
   assign host.host_nmi   = nmi_q;
   assign O_vid_addr      = v_s[13:0];
   assign O_vid_wren      = wr_s && (addr_q == REG_DATA);
   assign O_vid_data      = wdata_q;
   assign O_oam_addr      = oam_addr_q;
   assign O_oam_wren      = wr_s && (addr_q == REG_OAMDATA);
   assign O_oam_data      = wdata_q;
   assign O_ctrl          = ctrl_q;
   assign O_mask          = mask_q;
   assign O_vram_v        = v_s;

endmodule

// File: tb/tb_video_regs.sv
// Directed bench for video_regs: two instances (VRAM latency 1 and 3) share
// every stimulus; a small VRAM model with matching pipelines feeds each.
module tb_video_regs;

   logic       clk;
   logic       rst_n;
   logic       set_vbl, clr_vbl, s0_hit, spr_ovf;
   logic [3:0] hooks;          // {inc_y, inc_x, copy_v, copy_h}
   logic [7:0] pal_data, oam_rdata;

   int n_checks = 0;
   int n_errors = 0;

   video_regs_if hif1 ();
   video_regs_if hif3 ();

   assign hif3.host_addr  = hif1.host_addr;
   assign hif3.host_wren  = hif1.host_wren;
   assign hif3.host_rden  = hif1.host_rden;
   assign hif3.host_wdata = hif1.host_wdata;

   logic [13:0] vaddr1, vaddr3;
   logic        vwren1, vwren3, owren1, owren3;
   logic [7:0]  vwdata1, vwdata3, owdata1, owdata3, ctrl1, ctrl3, mask1, mask3;
   logic [7:0]  oaddr1, oaddr3, vrd1, vrd3;
   logic [14:0] v1, v3;
   logic [2:0]  fx1, fx3;
   logic [7:0]  p3a, p3b;

   video_regs #(.P_vram_latency(1), .P_palette_bypass(1), .P_oam_addr_width(8)) dut1 (
      .I_clock(clk), .I_reset(rst_n), .host(hif1),
      .I_set_vblank(set_vbl), .I_clr_vblank(clr_vbl),
      .I_sprite0_hit(s0_hit), .I_sprite_ovf(spr_ovf),
      .I_v_copy_h(hooks[0]), .I_v_copy_v(hooks[1]), .I_v_inc_x(hooks[2]), .I_v_inc_y(hooks[3]),
      .O_vid_addr(vaddr1), .O_vid_wren(vwren1), .I_vid_data(vrd1), .O_vid_data(vwdata1),
      .I_pal_data(pal_data), .O_oam_addr(oaddr1), .O_oam_wren(owren1), .O_oam_data(owdata1),
      .I_oam_data(oam_rdata), .O_ctrl(ctrl1), .O_mask(mask1), .O_vram_v(v1), .O_fine_x(fx1)
   );

   video_regs #(.P_vram_latency(3), .P_palette_bypass(1), .P_oam_addr_width(8)) dut3 (
      .I_clock(clk), .I_reset(rst_n), .host(hif3),
      .I_set_vblank(set_vbl), .I_clr_vblank(clr_vbl),
      .I_sprite0_hit(s0_hit), .I_sprite_ovf(spr_ovf),
      .I_v_copy_h(hooks[0]), .I_v_copy_v(hooks[1]), .I_v_inc_x(hooks[2]), .I_v_inc_y(hooks[3]),
      .O_vid_addr(vaddr3), .O_vid_wren(vwren3), .I_vid_data(vrd3), .O_vid_data(vwdata3),
      .I_pal_data(pal_data), .O_oam_addr(oaddr3), .O_oam_wren(owren3), .O_oam_data(owdata3),
      .I_oam_data(oam_rdata), .O_ctrl(ctrl3), .O_mask(mask3), .O_vram_v(v3), .O_fine_x(fx3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // VRAM contents used by the read tests
   function automatic logic [7:0] vram(input logic [13:0] a);
      case (a)
         14'h0000: return 8'h77;
         14'h2000: return 8'h11;
         14'h2001: return 8'h22;
         default:  return 8'h00;
      endcase
   endfunction

   // VRAM read pipelines: one stage for dut1, three for dut3
   always @(posedge clk) begin
      vrd1 <= vram(vaddr1);
      p3a  <= vram(vaddr3);
      p3b  <= p3a;
      vrd3 <= p3b;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Values seen during the strobe cycle of the last access (dut1)
   logic        s_vwren, s_owren;
   logic [13:0] s_vaddr;
   logic [7:0]  s_vdata, s_oaddr, s_odata;

   // One host access; optionally pulses I_set_vblank in the strobe cycle
   task automatic host_acc(input logic wr, input logic rd, input logic [2:0] a,
                           input logic [7:0] d, input logic set_in_s);
      @(negedge clk);
      hif1.host_addr  = a;
      hif1.host_wdata = d;
      hif1.host_wren  = wr;
      hif1.host_rden  = rd;
      @(negedge clk);
      hif1.host_wren = 1'b0;
      hif1.host_rden = 1'b0;
      set_vbl  = set_in_s;
      s_vwren  = vwren1;
      s_vaddr  = vaddr1;
      s_vdata  = vwdata1;
      s_owren  = owren1;
      s_oaddr  = oaddr1;
      s_odata  = owdata1;
      @(negedge clk);
      set_vbl = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
      host_acc(1'b1, 1'b0, a, d, 1'b0);
   endtask

   task automatic rd_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
      host_acc(1'b0, 1'b1, a, 8'h00, 1'b0);
      check({tag, "_l1"}, {24'd0, hif1.host_rdata}, {24'd0, exp});
      check({tag, "_l3"}, {24'd0, hif3.host_rdata}, {24'd0, exp});
   endtask

   task automatic hook(input logic [3:0] h, input int n);
      @(negedge clk);
      hooks = h;
      repeat (n) @(negedge clk);
      hooks = 4'b0000;
   endtask

   task automatic pulse_vbl(input logic set_p, input logic clr_p);
      @(negedge clk);
      set_vbl = set_p;
      clr_vbl = clr_p;
      @(negedge clk);
      set_vbl = 1'b0;
      clr_vbl = 1'b0;
   endtask

   initial begin
      hif1.host_addr = 3'd0; hif1.host_wdata = 8'd0;
      hif1.host_wren = 1'b0; hif1.host_rden  = 1'b0;
      set_vbl = 1'b0; clr_vbl = 1'b0; s0_hit = 1'b0; spr_ovf = 1'b0;
      hooks = 4'b0000; pal_data = 8'h1C; oam_rdata = 8'h5A;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      check("rst_rdata", {24'd0, hif1.host_rdata}, 32'h0);
      check("rst_nmi",   {31'd0, hif1.host_nmi},   32'h1);
      check("rst_v",     {17'd0, v1},              32'h0);
      check("rst_ctrl",  {24'd0, ctrl1},           32'h0);
      check("rst_vwren", {31'd0, vwren1},          32'h0);

      // Address write then data write
      wr_reg(3'd6, 8'h21);
      wr_reg(3'd6, 8'h08);
      check("addr_v", {17'd0, v1}, 32'h2108);
      wr_reg(3'd7, 8'hAA);
      check("w7_addr",  {18'd0, s_vaddr}, 32'h2108);
      check("w7_wren",  {31'd0, s_vwren}, 32'h1);
      check("w7_data",  {24'd0, s_vdata}, 32'hAA);
      check("w7_wren0", {31'd0, vwren1},  32'h0);
      check("w7_vinc",  {17'd0, v1},      32'h2109);

      // Buffered reads at 0x2000 on both latencies
      wr_reg(3'd6, 8'h20);
      wr_reg(3'd6, 8'h00);
      rd_check("rd_stale", 3'd7, 8'h00);
      rd_check("rd_first", 3'd7, 8'h11);
      check("rd_v_l1", {17'd0, v1}, 32'h2002);
      check("rd_v_l3", {17'd0, v3}, 32'h2002);
      rd_check("rd_second", 3'd7, 8'h22);

      // Palette bypass
      wr_reg(3'd6, 8'h3F);
      wr_reg(3'd6, 8'h05);
      rd_check("pal", 3'd7, 8'h1C);

      // Vblank NMI and status read
      wr_reg(3'd0, 8'h80);
      check("nmi_idle", {31'd0, hif1.host_nmi}, 32'h1);
      pulse_vbl(1'b1, 1'b0);
      @(negedge clk);
      check("nmi_low", {31'd0, hif1.host_nmi}, 32'h0);
      rd_check("status_vbl", 3'd2, 8'h80);
      check("nmi_high", {31'd0, hif1.host_nmi}, 32'h1);

      // Status read coincident with set: suppressed
      host_acc(1'b0, 1'b1, 3'd2, 8'h00, 1'b1);
      check("supp_rd", {24'd0, hif1.host_rdata}, 32'h00);
      repeat (3) @(negedge clk);
      check("supp_nmi", {31'd0, hif1.host_nmi}, 32'h1);
      s0_hit = 1'b1; spr_ovf = 1'b1;
      rd_check("status_flags", 3'd2, 8'h60);
      s0_hit = 1'b0; spr_ovf = 1'b0;

      // Set and clear together: clear wins
      pulse_vbl(1'b1, 1'b1);
      repeat (2) @(negedge clk);
      check("clr_wins_nmi", {31'd0, hif1.host_nmi}, 32'h1);

      // Scroll writes, copies and coarse X wrap
      wr_reg(3'd5, 8'h7D);
      wr_reg(3'd5, 8'h5E);
      check("fine_x", {29'd0, fx1}, 32'h5);
      hook(4'b0011, 1);
      check("copy_hv", {17'd0, v1}, 32'h616F);
      hook(4'b0100, 17);
      check("incx_wrap", {17'd0, v1}, 32'h6560);
      hook(4'b0100, 15);
      check("incx_32", {17'd0, v1}, 32'h656F);

      // Fine/coarse Y wrap at row 29 and row 31
      wr_reg(3'd5, 8'h00);
      wr_reg(3'd5, 8'hEF);
      hook(4'b0010, 1);
      check("copy_v", {17'd0, v1}, 32'h77AF);
      hook(4'b1000, 1);
      check("incy_29", {17'd0, v1}, 32'h0C0F);
      wr_reg(3'd5, 8'h00);
      wr_reg(3'd5, 8'hFF);
      hook(4'b0010, 1);
      hook(4'b1000, 1);
      check("incy_31", {17'd0, v1}, 32'h040F);

      // OAM write with address wrap, OAM read without increment
      wr_reg(3'd3, 8'hFF);
      wr_reg(3'd4, 8'h33);
      check("oam_wren", {31'd0, s_owren}, 32'h1);
      check("oam_addr_s", {24'd0, s_oaddr}, 32'hFF);
      check("oam_data", {24'd0, s_odata}, 32'h33);
      check("oam_wrap", {24'd0, oaddr1}, 32'h00);
      rd_check("oam_rd", 3'd4, 8'h5A);
      check("oam_noinc", {24'd0, oaddr1}, 32'h00);

      // Increment by 32
      wr_reg(3'd0, 8'h84);
      wr_reg(3'd6, 8'h21);
      wr_reg(3'd6, 8'h08);
      wr_reg(3'd7, 8'h55);
      check("inc32_addr", {18'd0, s_vaddr}, 32'h2108);
      check("inc32_v", {17'd0, v1}, 32'h2128);

      // Write and read strobed together: write wins
      pulse_vbl(1'b1, 1'b0);
      @(negedge clk);
      check("both_nmi_pre", {31'd0, hif1.host_nmi}, 32'h0);
      host_acc(1'b1, 1'b1, 3'd2, 8'h1F, 1'b0);
      check("both_rdata", {24'd0, hif1.host_rdata}, 32'h5A);
      check("both_nmi", {31'd0, hif1.host_nmi}, 32'h0);
      rd_check("status_ob", 3'd2, 8'h9F);
      check("status_ob_nmi", {31'd0, hif1.host_nmi}, 32'h1);

      // Reset while a fetch is in flight
      wr_reg(3'd6, 8'h20);
      wr_reg(3'd6, 8'h00);
      @(negedge clk);
      hif1.host_addr = 3'd7;
      hif1.host_rden = 1'b1;
      @(negedge clk);
      hif1.host_rden = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("mid_rst_rdata", {24'd0, hif3.host_rdata}, 32'h0);
      check("mid_rst_v", {17'd0, v3}, 32'h0);
      rd_check("mid_rst_buf", 3'd7, 8'h00);
      rd_check("post_rst_rd", 3'd7, 8'h77);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/video_regs.md
Name: video_regs

Overview:
- Host-visible PPU register file and VRAM/OAM access engine.
- Sits between the CPU bus (3-bit register window) and the video core. It owns control/mask/status, the scroll/address "t/v/fine-x/w" state, the buffered VRAM data port, OAM address/data, the vblank flag and NMI.
- Parametrised successor of the fixed register decode: configurable VRAM read latency, palette read bypass, OAM width, and renderer scroll-update hooks.

Parameters:
P_vram_latency, 1, clocks from O_vid_addr presented to I_vid_data valid (1..3)
P_palette_bypass, 1, 1 = PPUDATA reads at v[13:8]==6'h3F return I_pal_data directly
P_oam_addr_width, 8, OAM address width

Ports:
I_clock  in  1  system clock
I_reset  in  1  asynchronous, active-low reset
I_host_addr  in  3  register index 0..7
I_host_wren  in  1  write level; internal rising-edge strobe
I_host_rden  in  1  read level; internal rising-edge strobe
I_host_data  in  8  write data
O_host_data  out  8  registered read data
O_host_nmi  out  1  active-low NMI
I_set_vblank  in  1  one-cycle pulse from timing (line 241, dot 0)
I_clr_vblank  in  1  one-cycle pulse from timing (pre-render line)
I_sprite0_hit, I_sprite_ovf  in  1  status bits, level, from renderer
I_v_copy_h, I_v_copy_v, I_v_inc_x, I_v_inc_y  in  1  renderer scroll hooks
O_vid_addr  out  14  VRAM address
O_vid_wren  out  1  VRAM write strobe
I_vid_data  in  8  VRAM read data
O_vid_data  out  8  VRAM write data
I_pal_data  in  8  palette read data (combinational on O_vid_addr)
O_oam_addr  out  P_oam_addr_width  OAM address
O_oam_wren  out  1  OAM write strobe
O_oam_data  out  8  OAM write data
I_oam_data  in  8  OAM read data
O_ctrl, O_mask  out  8  control / mask registers
O_vram_v  out  15  current scroll/address register v
O_fine_x  out  3  fine X scroll

Behaviour:
- Reset: every register 0, w=0, read buffer 0, O_host_nmi=1, strobes 0, O_host_data=0.
- Strobe cycle S: one clock after the rising edge of wren/rden. Strobes are at least 2 clocks apart. If wren and rden are both strobed, the write wins.
- O_host_data updates at the end of S. It holds until the next read. Any write loads the open-bus latch.
- Reg0 write: ctrl<=d; t[11:10]<=d[1:0]. Reg1 write: mask<=d. Reg3 write: oam_addr<=d.
- Reg2 read: returns {vblank, I_sprite0_hit, I_sprite_ovf, openbus[4:0]}. Clears vblank and w.
- Reg4 write: O_oam_wren=1 for cycle S; oam_addr increments with wrap. Reg4 read: returns I_oam_data; no increment.
- Reg5 write, w=0: t[4:0]<=d[7:3]; fine_x<=d[2:0]. Reg5 write, w=1: t[9:5]<=d[7:3]; t[14:12]<=d[2:0]. Every reg5/reg6 write toggles w.
- Reg6 write, w=0: t[13:8]<=d[5:0]; t[14]<=0. Reg6 write, w=1: t[7:0]<=d; v<=new t, effective the next clock.
- Reg7 write: for cycle S, O_vid_addr=v[13:0], O_vid_data=d, O_vid_wren=1. v increments by 1 (ctrl[2]=0) or 32 (ctrl[2]=1), mod 2^15.
- Reg7 read: returns the read buffer, or I_pal_data if P_palette_bypass and v is in the palette region. A VRAM fetch of v is issued in S. The buffer captures I_vid_data at S+P_vram_latency (palette reads still refill the buffer). v increments at the end of S.
- Renderer hooks act at the clock edge. Priority: host v update > copy > inc.
  - copy_h: v[10],v[4:0] <= t.
  - copy_v: v[14:11],v[9:5] <= t.
  - inc_x: coarse X +1; at 31 wraps to 0 and toggles v[10].
  - inc_y: fine Y +1; on overflow coarse Y +1; coarse Y 29 wraps to 0 and toggles v[11]; coarse Y 31 wraps to 0 with no toggle.
- Vblank flag:
  - set on I_set_vblank; cleared by I_clr_vblank or a status read.
  - status read in the same cycle as I_set_vblank: bit7 reads 0 and the flag stays clear (suppression).
  - I_set_vblank and I_clr_vblank together: clear wins.
- NMI: O_host_nmi is registered as ~(vblank & ctrl[7]). Setting ctrl[7] 0->1 while vblank=1 drives it low the next clock.
- Reset mid-access: the pending VRAM fetch is discarded and the buffer is zeroed.

Decomposition:
- video_pkg holds:
  - register index localparams (0..7);
  - ctrl bit positions (increment, NMI enable);
  - status bit positions;
  - the palette region constant 6'h3F.
- Reuse the existing edge_trig for the strobes.
- One natural sub-module: video_scroll, holding t/v/fine_x/w, the copy/increment hooks and coarse/fine wrap logic.

Test Plan:
- Reg6 writes 8'h21 then 8'h08, then reg7 write 8'hAA with ctrl[2]=0 -> O_vid_addr=14'h2108 with O_vid_wren=1 for 1 clock; O_vram_v becomes 15'h2109.
- Reg7 reads with VRAM[0x2000]=8'h11 and VRAM[0x2001]=8'h22, starting at v=0x2000 -> reads return stale buffer, then 8'h11; v ends at 0x2002. Repeat with P_vram_latency=3.
- Palette read at v=0x3F05 with I_pal_data=8'h1C -> returns 8'h1C immediately.
- Set ctrl=8'h80, then pulse I_set_vblank -> O_host_nmi goes low next clock; status read returns 8'h80|openbus, then NMI returns high.
- Status read strobe coincident with I_set_vblank -> bit7=0, flag remains clear, NMI stays high.
- Reg5 writes 8'h7D then 8'h5E -> fine_x=5, t[4:0]=15, t[9:5]=11, t[14:12]=6. Then 32 inc_x pulses -> coarse X wraps and v[10] toggles.
